// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: requester-select encoding and default
// datapath widths matching the core.
package dmem_arb_pkg;

  localparam logic SEL_CPU = 1'b0;
  localparam logic SEL_DMA = 1'b1;

  localparam int unsigned DMEM_DW = 32;
  localparam int unsigned DMEM_AW = 32;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin grant between CPU and DMA, with a DMA lock whose length is bounded
// only while the CPU is waiting.
module arb_rr2
  import dmem_arb_pkg::*;
#(
  parameter int unsigned MaxBurst = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_req_i,
  input  logic dma_req_i,
  input  logic dma_lock_i,
  output logic cpu_gnt_o,
  output logic dma_gnt_o
);

  localparam int unsigned    BW       = $clog2(MaxBurst) + 1;
  localparam logic [BW-1:0] BurstMax = BW'(MaxBurst);

  logic          last_gnt_q, last_gnt_d;
  logic          locked_q, locked_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic          burst_spent;

  // The burst limit only bites when the CPU is actually waiting.
  assign burst_spent = cpu_req_i & (burst_cnt_q >= BurstMax);

  always_comb begin
    cpu_gnt_o = 1'b0;
    dma_gnt_o = 1'b0;
    if (!reset) begin
      if (locked_q && dma_req_i && !burst_spent) begin
        dma_gnt_o = 1'b1;
      end else if (cpu_req_i && dma_req_i) begin
        if (last_gnt_q == SEL_CPU) begin
          dma_gnt_o = 1'b1;
        end else begin
          cpu_gnt_o = 1'b1;
        end
      end else if (cpu_req_i) begin
        cpu_gnt_o = 1'b1;
      end else if (dma_req_i) begin
        dma_gnt_o = 1'b1;
      end
    end
  end

  always_comb begin
    last_gnt_d  = last_gnt_q;
    locked_d    = 1'b0;
    burst_cnt_d = '0;
    if (cpu_gnt_o) begin
      last_gnt_d = SEL_CPU;
    end else if (dma_gnt_o) begin
      last_gnt_d = SEL_DMA;
    end
    if (dma_gnt_o && dma_lock_i) begin
      locked_d    = 1'b1;
      burst_cnt_d = (burst_cnt_q == BurstMax) ? burst_cnt_q : burst_cnt_q + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt_q  <= SEL_DMA;
      locked_q    <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      locked_q    <= locked_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the CPU memory stage and the DMA/debug loader;
// grants are decided in the same cycle so a granted access completes in one clock.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DW        = DMEM_DW,
  parameter int unsigned AW        = DMEM_AW,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [AW-1:0]    cpu_a,
  input  logic [DW-1:0]    cpu_wd,
  output logic             cpu_gnt,
  output logic [DW-1:0]    cpu_rd,
  output logic             stall_cpu,
  input  logic             dma_req,
  input  logic             dma_lock,
  input  logic             dma_we,
  input  logic [AW-1:0]    dma_a,
  input  logic [DW-1:0]    dma_wd,
  output logic             dma_gnt,
  output logic [DW-1:0]    dma_rd,
  output logic             mem_we,
  output logic [AW-1:0]    mem_a,
  output logic [DW-1:0]    mem_wd,
  input  logic [DW-1:0]    mem_rd,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             sel;
  logic [CNT_W-1:0] stall_cnt_q;

  arb_rr2 #(
    .MaxBurst(MAX_BURST)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .cpu_req_i (cpu_req),
    .dma_req_i (dma_req),
    .dma_lock_i(dma_lock),
    .cpu_gnt_o (cpu_gnt),
    .dma_gnt_o (dma_gnt)
  );

  // With no grant the port idles on the CPU side with writes suppressed.
  always_comb begin
    sel    = dma_gnt ? SEL_DMA : SEL_CPU;
    mem_a  = (sel == SEL_DMA) ? dma_a : cpu_a;
    mem_wd = (sel == SEL_DMA) ? dma_wd : cpu_wd;
    mem_we = (cpu_gnt & cpu_we) | (dma_gnt & dma_we);
  end

  assign cpu_rd    = mem_rd;
  assign dma_rd    = mem_rd;
  assign stall_cpu = cpu_req & ~cpu_gnt & ~reset;
  assign stall_cnt = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall_cpu && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

endmodule
